// File: rtl/calc_pkg.sv
// Shared definitions for the 4-register calculator: opcodes, SEND sequencer
// states and the nibble-to-ASCII helper used when printing a register.
package calc_pkg;

   localparam logic [1:0] OP_PUSH = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_MULT = 2'b10;
   localparam logic [1:0] OP_SEND = 2'b11;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   // One state per byte of a SEND message: hex high digit, hex low digit, CR, LF.
   typedef enum logic [1:0] {
      SEQ_HI = 2'd0,
      SEQ_LO = 2'd1,
      SEQ_CR = 2'd2,
      SEQ_LF = 2'd3
   } seq_state_e;

   // Uppercase ASCII hex digit for a nibble.
   function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
      if (nib < 4'd10) begin
         return 8'h30 + {4'h0, nib};
      end
      return 8'h37 + {4'h0, nib};
   endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. A byte is accepted when start is high and busy is low.
// busy drops during the final clock of the stop bit so the next byte can be
// accepted in that cycle and follow with no idle gap.
module uart_tx
   import calc_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 1_000_000
) (
   input  logic       clk,
   input  logic       btnR,
   input  logic [7:0] data,
   input  logic       start,
   output logic       busy,
   output logic       tx
);

   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic          active_q, active_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [8:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          last_tick;

   // bit_q == 9 is the stop bit; its final clock is the hand-over point.
   assign last_tick = active_q && (bit_q == 4'd9) && (cnt_q == CW'(DIV - 1));
   assign busy      = active_q && !last_tick;
   assign tx        = tx_q;

   // Next-state: load a new frame, or advance the bit timer and shifter.
   always_comb begin
      active_d = active_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      if (start && !busy) begin
         active_d = 1'b1;
         cnt_d    = '0;
         bit_d    = 4'd0;
         shift_d  = {1'b1, data};
         tx_d     = 1'b0;
      end else if (active_q) begin
         if (cnt_q == CW'(DIV - 1)) begin
            cnt_d = '0;
            if (bit_q == 4'd9) begin
               active_d = 1'b0;
               tx_d     = 1'b1;
            end else begin
               bit_d   = bit_q + 4'd1;
               tx_d    = shift_q[0];
               shift_d = {1'b1, shift_q[8:1]};
            end
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Frame state registers; reset forces the line idle and aborts any frame.
   always_ff @(posedge clk or negedge btnR) begin
      if (!btnR) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
         bit_q    <= 4'd0;
         shift_q  <= '1;
         tx_q     <= 1'b1;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end

endmodule

// File: rtl/nexys3_calc_top.sv
// Board top of the 4 x 8-bit register calculator. A debounced press of btnS
// executes the instruction on sw; SEND prints a register as "HH\r\n" on RsTx.
// Valid/ready rule between the SEND sequencer and uart_tx: a byte moves in a
// cycle where tx_start is high and tx_busy is low; tx_byte must hold meanwhile.
module nexys3_calc_top
   import calc_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int BAUD         = 1_000_000,
   parameter int DEBOUNCE_CYC = 100_000
) (
   input  logic       clk,
   input  logic       btnR,
   input  logic       btnS,
   input  logic [7:0] sw,
   input  logic       RsRx,
   output logic       RsTx,
   output logic [7:0] led
);

   localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);

   logic             rsrx_unused;
   logic [1:0]       sync_q;
   logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic             db_lvl_q, db_lvl_d, db_prev_q;
   logic             busy, inst_vld;
   logic [7:0]       inst_wd;
   logic [1:0]       op, ra, rb, rc;
   logic [3:0][7:0]  regs_q, regs_d;
   logic [7:0]       led_q, led_d;
   seq_state_e       seq_state_q, seq_state_d;
   logic             seq_active_q, seq_active_d;
   logic [7:0]       snap_q, snap_d;
   logic             tx_start, tx_busy;
   logic [7:0]       tx_byte;

   assign rsrx_unused = RsRx;

   assign inst_wd = sw;
   assign op      = inst_wd[7:6];
   assign ra      = inst_wd[5:4];
   assign rb      = inst_wd[3:2];
   assign rc      = inst_wd[1:0];

   // Busy covers the whole SEND message, including byte hand-overs.
   assign busy     = seq_active_q | tx_busy;
   assign inst_vld = db_lvl_q & ~db_prev_q & ~busy;
   assign led      = led_q;

   // Two-flop synchronizer for the raw button.
   always_ff @(posedge clk or negedge btnR) begin
      if (!btnR) sync_q <= 2'b00;
      else       sync_q <= {sync_q[0], btnS};
   end

   // Debouncer: level follows the button only after DEBOUNCE_CYC stable cycles.
   always_comb begin
      db_cnt_d = db_cnt_q;
      db_lvl_d = db_lvl_q;
      if (sync_q[1] == db_lvl_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
         db_lvl_d = sync_q[1];
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + DB_W'(1);
      end
   end

   // Execute: ADD/MULT read the old register values before any write.
   always_comb begin
      regs_d = regs_q;
      led_d  = led_q;
      if (inst_vld) begin
         led_d = inst_wd;
         case (op)
            OP_PUSH: regs_d[ra] = {regs_q[ra][3:0], inst_wd[3:0]};
            OP_ADD:  regs_d[rc] = regs_q[ra] + regs_q[rb];
            OP_MULT: regs_d[rc] = regs_q[ra] * regs_q[rb];
            default: ;
         endcase
      end
   end

   // SEND sequencer: snapshot the register, then hand four bytes to the UART.
   always_comb begin
      seq_state_d  = seq_state_q;
      seq_active_d = seq_active_q;
      snap_d       = snap_q;
      tx_start     = 1'b0;
      case (seq_state_q)
         SEQ_HI:  tx_byte = hex_to_ascii(snap_q[7:4]);
         SEQ_LO:  tx_byte = hex_to_ascii(snap_q[3:0]);
         SEQ_CR:  tx_byte = ASCII_CR;
         default: tx_byte = ASCII_LF;
      endcase
      if (seq_active_q && !tx_busy) begin
         tx_start = 1'b1;
         case (seq_state_q)
            SEQ_HI:  seq_state_d = SEQ_LO;
            SEQ_LO:  seq_state_d = SEQ_CR;
            SEQ_CR:  seq_state_d = SEQ_LF;
            default: begin
               seq_state_d  = SEQ_HI;
               seq_active_d = 1'b0;
            end
         endcase
      end
      if (inst_vld && (op == OP_SEND)) begin
         seq_active_d = 1'b1;
         seq_state_d  = SEQ_HI;
         snap_d       = regs_q[ra];
      end
   end

   // Architectural and control state registers.
   always_ff @(posedge clk or negedge btnR) begin
      if (!btnR) begin
         db_cnt_q     <= '0;
         db_lvl_q     <= 1'b0;
         db_prev_q    <= 1'b0;
         regs_q       <= '0;
         led_q        <= 8'h00;
         seq_state_q  <= SEQ_HI;
         seq_active_q <= 1'b0;
         snap_q       <= 8'h00;
      end else begin
         db_cnt_q     <= db_cnt_d;
         db_lvl_q     <= db_lvl_d;
         db_prev_q    <= db_lvl_q;
         regs_q       <= regs_d;
         led_q        <= led_d;
         seq_state_q  <= seq_state_d;
         seq_active_q <= seq_active_d;
         snap_q       <= snap_d;
      end
   end

   uart_tx #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_uart_tx (
      .clk   (clk),
      .btnR  (btnR),
      .data  (tx_byte),
      .start (tx_start),
      .busy  (tx_busy),
      .tx    (RsTx)
   );

endmodule

// File: tb/tb_nexys3_calc_top.sv
// Bench for nexys3_calc_top. The debounce time is shortened to 100 cycles and
// every press/wait interval is scaled with it; the UART runs at the real
// 100 clocks per bit so the receiver model uses true 1 Mbaud bit times.
module tb_nexys3_calc_top;

   localparam int CLK_P = 10;
   localparam int DEB   = 100;
   localparam int BIT_T = 100 * CLK_P;

   logic       clk = 1'b0;
   logic       btnR, btnS, RsRx, RsTx;
   logic [7:0] sw, led;

   int         n_checks = 0;
   int         n_errors = 0;
   int         vld_cnt  = 0;
   int         rx_cnt   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] model_r[4];
   logic [7:0] model_led;

   nexys3_calc_top #(
      .CLK_HZ       (100_000_000),
      .BAUD         (1_000_000),
      .DEBOUNCE_CYC (DEB)
   ) dut (
      .clk  (clk),
      .btnR (btnR),
      .btnS (btnS),
      .sw   (sw),
      .RsRx (RsRx),
      .RsTx (RsTx),
      .led  (led)
   );

   // ---------------- clock / reset ----------------
   always #(CLK_P / 2) clk = ~clk;

   initial begin
      #(CLK_P * 200000);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ascii_hex(input logic [3:0] n);
      logic [7:0] t;
      if (n <= 4'd9) t = 8'd48 + 8'(n);
      else           t = 8'd65 + 8'(n - 4'd10);
      return t;
   endfunction

   // Reference model of one executed instruction.
   task automatic apply_model(input logic [7:0] w);
      logic [1:0]  op, ra, rb, rc;
      logic [8:0]  sum;
      logic [15:0] prod;
      op = w[7:6]; ra = w[5:4]; rb = w[3:2]; rc = w[1:0];
      sum  = {1'b0, model_r[ra]} + {1'b0, model_r[rb]};
      prod = {8'h00, model_r[ra]} * {8'h00, model_r[rb]};
      case (op)
         2'b00: model_r[ra] = {model_r[ra][3:0], w[3:0]};
         2'b01: model_r[rc] = sum[7:0];
         2'b10: model_r[rc] = prod[7:0];
         default: begin
            exp_q.push_back(ascii_hex(model_r[ra][7:4]));
            exp_q.push_back(ascii_hex(model_r[ra][3:0]));
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
         end
      endcase
      model_led = w;
   endtask

   // Count executed instructions, sampled away from the active edge.
   always @(negedge clk) begin
      if (btnR && dut.inst_vld) vld_cnt++;
   end

   // UART receiver model: checks framing, back-to-back spacing and bytes.
   initial begin
      longint     t_prev, t_now;
      logic [7:0] b;
      t_prev = 0;
      forever begin
         @(negedge RsTx);
         t_now = $time;
         if (rx_cnt % 4 != 0) check_val("uart_gap", 32'(t_now - t_prev), 32'(10 * BIT_T));
         t_prev = t_now;
         #(BIT_T / 2);
         check_val("uart_start", 32'(RsTx), 32'(0));
         for (int i = 0; i < 8; i++) begin
            #(BIT_T);
            b[i] = RsTx;
         end
         #(BIT_T);
         check_val("uart_stop", 32'(RsTx), 32'(1));
         check_val("uart_expected", 32'(exp_q.size() != 0), 32'(1));
         if (exp_q.size() != 0) check_val("uart_byte", 32'(b), 32'(exp_q.pop_front()));
         rx_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [7:0] w, input bit exec, input string tag);
      int v0;
      sw = w;
      wait_clk(DEB * 3 / 2);
      v0 = vld_cnt;
      if (exec) apply_model(w);
      btnS = 1'b1;
      wait_clk(DEB * 3);
      btnS = 1'b0;
      wait_clk(4);
      check_val({tag, "_vld"}, 32'(vld_cnt - v0), exec ? 32'(1) : 32'(0));
      check_val({tag, "_led"}, 32'(led), 32'(model_led));
      for (int r = 0; r < 4; r++)
         check_val($sformatf("%s_r%0d", tag, r), 32'(dut.regs_q[r]), 32'(model_r[r]));
   endtask

   task automatic drain_tx(input string tag);
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 20000) begin
         wait_clk(1);
         budget++;
      end
      check_val({tag, "_drain"}, 32'(exp_q.size()), 32'(0));
      wait_clk(100);
      check_val({tag, "_idle"}, 32'(RsTx), 32'(1));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int v0;
      btnR = 1'b1; btnS = 1'b0; sw = 8'h00; RsRx = 1'b1;
      for (int r = 0; r < 4; r++) model_r[r] = 8'h00;
      model_led = 8'h00;

      #(CLK_P * 2);
      btnR = 1'b0;
      wait_clk(5);
      check_val("reset_led", 32'(led), 32'(8'h00));
      check_val("reset_tx", 32'(RsTx), 32'(1));
      for (int r = 0; r < 4; r++)
         check_val($sformatf("reset_r%0d", r), 32'(dut.regs_q[r]), 32'(0));
      btnR = 1'b1;
      wait_clk(DEB * 3 / 2);
      check_val("idle_vld", 32'(vld_cnt), 32'(0));
      check_val("idle_rx", 32'(rx_cnt), 32'(0));
      check_val("idle_tx", 32'(RsTx), 32'(1));

      press(8'h04, 1'b1, "push0_4");
      press(8'h00, 1'b1, "push0_0");
      check_val("r0_is_40", 32'(dut.regs_q[0]), 32'(8'h40));
      press(8'h13, 1'b1, "push1_3");
      press(8'hA6, 1'b1, "mult2_1_2");
      press(8'h86, 1'b1, "mult0_1_2");
      check_val("r2_is_c0", 32'(dut.regs_q[2]), 32'(8'hC0));
      press(8'h63, 1'b1, "add2_0_3");
      press(8'h55, 1'b1, "add1_1_1");
      press(8'h95, 1'b1, "mult1_1_1");

      press(8'hC0, 1'b1, "send0");
      drain_tx("send0");
      check_val("send0_bytes", 32'(rx_cnt), 32'(4));
      press(8'hE0, 1'b1, "send2");
      drain_tx("send2");
      check_val("send2_bytes", 32'(rx_cnt), 32'(8));

      // Short glitch must not reach the debounced level.
      v0 = vld_cnt;
      btnS = 1'b1;
      wait_clk(DEB / 2);
      btnS = 1'b0;
      wait_clk(DEB * 3);
      check_val("glitch_vld", 32'(vld_cnt - v0), 32'(0));
      check_val("glitch_led", 32'(led), 32'(model_led));

      // A press while SEND is transmitting is dropped.
      press(8'hD0, 1'b1, "send1");
      press(8'h3F, 1'b0, "lockout");
      drain_tx("send1");
      check_val("send1_bytes", 32'(rx_cnt), 32'(12));
      press(8'h3F, 1'b1, "push3_f");

      wait_clk(50);
      check_val("final_queue", 32'(exp_q.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
